// File: rtl/conv_loop_sched_if.sv
// Handshake/config bundle between the layer-config side, the scheduler and the
// CoreT MAC datapath. The scheduler connects through the slave modport.
interface conv_loop_sched_if #(
  parameter int FM_AW  = 16,
  parameter int WT_AW  = 16,
  parameter int OUT_AW = 16
);
  logic              start;
  logic [5:0]        H;
  logic [5:0]        W;
  logic [6:0]        C;
  logic [6:0]        K;
  logic [2:0]        hk;
  logic              mac_ready;
  logic              mac_valid;
  logic [FM_AW-1:0]  fm_addr;
  logic              pad;
  logic [WT_AW-1:0]  wt_addr;
  logic              acc_first;
  logic              acc_last;
  logic [OUT_AW-1:0] out_addr;
  logic              busy;
  logic              done;
  logic              cfg_err;

  modport master (
    output start, H, W, C, K, hk, mac_ready,
    input  mac_valid, fm_addr, pad, wt_addr, acc_first, acc_last, out_addr,
           busy, done, cfg_err
  );

  modport slave (
    input  start, H, W, C, K, hk, mac_ready,
    output mac_valid, fm_addr, pad, wt_addr, acc_first, acc_last, out_addr,
           busy, done, cfg_err
  );
endinterface

// File: rtl/conv_loop_sched.sv
// Convolution loop-nest scheduler: walks k, y, x, c, ky, kx and issues one
// registered MAC beat per accepted handshake, then drains and pulses done.
module conv_loop_sched #(
  parameter int FM_AW     = 16,
  parameter int WT_AW     = 16,
  parameter int OUT_AW    = 16,
  parameter int FLUSH_CYC = 4
) (
  input logic              clk,
  input logic              rst_n,
  conv_loop_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  typedef struct packed {
    logic [6:0] k;
    logic [5:0] y;
    logic [5:0] x;
    logic [6:0] c;
    logic [2:0] ky;
    logic [2:0] kx;
  } cnt_t;

  typedef struct packed {
    logic [FM_AW-1:0]  fm;
    logic              pad;
    logic [WT_AW-1:0]  wt;
    logic              first;
    logic              last;
    logic [OUT_AW-1:0] out;
  } beat_t;

  state_e     state_q;
  cnt_t       cnt_q, cnt_d;
  beat_t      beat_q, next_beat, start_beat;
  logic [5:0] cfg_h_q, cfg_w_q;
  logic [6:0] cfg_c_q, cfg_k_q;
  logic [2:0] cfg_hk_q;
  logic [3:0] flush_q;
  logic       mac_valid_q, busy_q, done_q, cfg_err_q;
  logic       kx_wrap, ky_wrap, c_wrap, x_wrap, y_wrap, k_wrap, last_beat;
  logic       cfg_ok;

  // Address formulas evaluated at 32-bit signed precision, then truncated.
  function automatic beat_t calc_beat(input cnt_t n, input logic [5:0] h,
                                      input logic [5:0] w, input logic [6:0] cc,
                                      input logic [2:0] hk);
    beat_t b;
    int p, iy, ix, fm, wt, oa;
    p  = (int'(hk) - 1) / 2;
    iy = int'(n.y) + int'(n.ky) - p;
    ix = int'(n.x) + int'(n.kx) - p;
    fm = (int'(n.c) * int'(h) + iy) * int'(w) + ix;
    wt = ((int'(n.k) * int'(cc) + int'(n.c)) * int'(hk) + int'(n.ky)) * int'(hk)
         + int'(n.kx);
    oa = (int'(n.k) * int'(h) + int'(n.y)) * int'(w) + int'(n.x);
    b.pad   = (iy < 0) || (iy >= int'(h)) || (ix < 0) || (ix >= int'(w));
    b.fm    = b.pad ? '0 : fm[FM_AW-1:0];
    b.wt    = wt[WT_AW-1:0];
    b.out   = oa[OUT_AW-1:0];
    b.first = (n.c == '0) && (n.ky == '0) && (n.kx == '0);
    b.last  = (n.c == cc - 7'd1) && (n.ky == hk - 3'd1) && (n.kx == hk - 3'd1);
    return b;
  endfunction

  assign cfg_ok = (bus.H != '0) && (bus.W != '0) && (bus.C != '0) &&
                  (bus.K != '0) && bus.hk[0];

  assign kx_wrap   = (cnt_q.kx == cfg_hk_q - 3'd1);
  assign ky_wrap   = (cnt_q.ky == cfg_hk_q - 3'd1);
  assign c_wrap    = (cnt_q.c  == cfg_c_q  - 7'd1);
  assign x_wrap    = (cnt_q.x  == cfg_w_q  - 6'd1);
  assign y_wrap    = (cnt_q.y  == cfg_h_q  - 6'd1);
  assign k_wrap    = (cnt_q.k  == cfg_k_q  - 7'd1);
  assign last_beat = kx_wrap && ky_wrap && c_wrap && x_wrap && y_wrap && k_wrap;

  // NOTE: cnt_d gets a full default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!kx_wrap) cnt_d.kx = cnt_q.kx + 3'd1;
    else begin
      cnt_d.kx = '0;
      if (!ky_wrap) cnt_d.ky = cnt_q.ky + 3'd1;
      else begin
        cnt_d.ky = '0;
        if (!c_wrap) cnt_d.c = cnt_q.c + 7'd1;
        else begin
          cnt_d.c = '0;
          if (!x_wrap) cnt_d.x = cnt_q.x + 6'd1;
          else begin
            cnt_d.x = '0;
            if (!y_wrap) cnt_d.y = cnt_q.y + 6'd1;
            else begin
              cnt_d.y = '0;
              cnt_d.k = cnt_q.k + 7'd1;
            end
          end
        end
      end
    end
  end

  assign next_beat  = calc_beat(cnt_d, cfg_h_q, cfg_w_q, cfg_c_q, cfg_hk_q);
  assign start_beat = calc_beat('0, bus.H, bus.W, bus.C, bus.hk);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      cfg_h_q     <= '0;
      cfg_w_q     <= '0;
      cfg_c_q     <= '0;
      cfg_k_q     <= '0;
      cfg_hk_q    <= '0;
      flush_q     <= '0;
      mac_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (cfg_ok) begin
              cfg_h_q     <= bus.H;
              cfg_w_q     <= bus.W;
              cfg_c_q     <= bus.C;
              cfg_k_q     <= bus.K;
              cfg_hk_q    <= bus.hk;
              cnt_q       <= '0;
              beat_q      <= start_beat;
              mac_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // Beat registers only move on an accepted handshake, so a stall holds them.
          if (bus.mac_ready) begin
            if (last_beat) begin
              mac_valid_q <= 1'b0;
              beat_q      <= '0;
              flush_q     <= '0;
              state_q     <= FLUSH;
            end else begin
              cnt_q  <= cnt_d;
              beat_q <= next_beat;
            end
          end
        end
        FLUSH: begin
          if (flush_q == 4'(FLUSH_CYC - 1)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            flush_q <= flush_q + 4'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mac_valid = mac_valid_q;
  assign bus.fm_addr   = beat_q.fm;
  assign bus.pad       = beat_q.pad;
  assign bus.wt_addr   = beat_q.wt;
  assign bus.acc_first = beat_q.first;
  assign bus.acc_last  = beat_q.last;
  assign bus.out_addr  = beat_q.out;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_conv_loop_sched.sv
// Scoreboard bench for conv_loop_sched: stimulus pushes expected beats, a
// negedge monitor pops them on each accepted beat and checks held values on stalls.
module tb_conv_loop_sched;
  localparam int FLUSH_CYC = 4;

  typedef struct packed {
    logic [15:0] fm;
    logic        pad;
    logic [15:0] wt;
    logic        first;
    logic        last;
    logic [15:0] out;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  beat_t exp_q[$];
  beat_t last_seen;
  int    n_pass = 0;
  int    n_total = 0;
  int    cyc = 0;
  int    beat_cnt = 0;
  int    ready_mode = 0;

  always #5 clk = ~clk;

  conv_loop_sched_if #(.FM_AW(16), .WT_AW(16), .OUT_AW(16)) bus ();

  conv_loop_sched #(
    .FM_AW(16), .WT_AW(16), .OUT_AW(16), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic beat_t mk(input logic [15:0] fm, input logic pad,
                               input logic [15:0] wt, input logic f,
                               input logic l, input logic [15:0] o);
    return {fm, pad, wt, f, l, o};
  endfunction

  // Reference beat stream straight from the loop-order and address formulas.
  task automatic gen_expected(input int h, input int w, input int c, input int k,
                              input int hk, input int skip);
    int idx = 0;
    int p = (hk - 1) / 2;
    for (int kk = 0; kk < k; kk++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++)
          for (int cc = 0; cc < c; cc++)
            for (int ky = 0; ky < hk; ky++)
              for (int kx = 0; kx < hk; kx++) begin
                int iy = y + ky - p;
                int ix = x + kx - p;
                logic pd = (iy < 0) || (iy >= h) || (ix < 0) || (ix >= w);
                int fm = pd ? 0 : (cc * h + iy) * w + ix;
                int wt = ((kk * c + cc) * hk + ky) * hk + kx;
                int oa = (kk * h + y) * w + x;
                if (idx >= skip)
                  exp_q.push_back(mk(fm[15:0], pd, wt[15:0],
                                     (cc == 0) && (ky == 0) && (kx == 0),
                                     (cc == c - 1) && (ky == hk - 1) && (kx == hk - 1),
                                     oa[15:0]));
                idx++;
              end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // mac_ready driver: always 1, or the repeating pattern 1,0,0,1.
  initial begin
    int ph = 0;
    bus.mac_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) begin
        bus.mac_ready = (ph % 4 == 0) || (ph % 4 == 3);
        ph++;
      end else begin
        bus.mac_ready = 1'b1;
      end
    end
  end

  initial begin
    beat_t cur;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mac_valid) begin
        cur = {bus.fm_addr, bus.pad, bus.wt_addr, bus.acc_first, bus.acc_last,
               bus.out_addr};
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got %h, expected no beat", cur);
        end else if (bus.mac_ready) begin
          check("beat", cur, exp_q.pop_front());
          beat_cnt++;
          last_seen = cur;
        end else begin
          check("stall_hold", cur, exp_q[0]);
        end
      end
    end
  end

  task automatic drive_cfg(input int h, input int w, input int c, input int k,
                           input int hk);
    bus.H  = 6'(h);
    bus.W  = 6'(w);
    bus.C  = 7'(c);
    bus.K  = 7'(k);
    bus.hk = 3'(hk);
  endtask

  task automatic run_layer(input int h, input int w, input int c, input int k,
                           input int hk, input int exp_lat, input bit chk_lat);
    int s_cyc, base, nbeats;
    bit got = 1'b0;
    nbeats = k * h * w * c * hk * hk;
    @(negedge clk);
    drive_cfg(h, w, c, k, hk);
    bus.start = 1'b1;
    s_cyc = cyc;
    base  = beat_cnt;
    @(negedge clk);
    bus.start = 1'b0;
    drive_cfg(0, 7, 0, 3, 2);
    check("busy_after_start", bus.busy, 1);
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    check("done_seen", got, 1);
    if (got) begin
      if (chk_lat) check("done_latency", cyc - s_cyc, exp_lat);
      check("busy_in_done", bus.busy, 1);
      check("beat_count", beat_cnt - base, nbeats);
      check("queue_drained", exp_q.size(), 0);
      drive_cfg(1, 1, 1, 1, 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("idle_after_done", {bus.busy, bus.done, bus.mac_valid}, 3'b000);
      @(negedge clk);
      check("done_cycle_start_ignored", {bus.busy, bus.mac_valid}, 2'b00);
    end
  endtask

  task automatic bad_start(input int h, input int w, input int c, input int k,
                           input int hk);
    @(negedge clk);
    drive_cfg(h, w, c, k, hk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("cfg_err_pulse", {bus.cfg_err, bus.busy, bus.mac_valid, bus.done}, 4'b1000);
    @(negedge clk);
    check("cfg_err_single", {bus.cfg_err, bus.busy, bus.mac_valid, bus.done}, 4'b0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] fm_t [9];
    logic        pad_t[9];
    bus.start = 1'b0;
    drive_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.mac_valid, bus.pad, bus.acc_first, bus.acc_last,
          bus.busy, bus.done, bus.cfg_err, bus.fm_addr, bus.wt_addr, bus.out_addr}, '0);
    rst_n = 1'b1;

    // Single-beat layer.
    exp_q.push_back(mk(16'd0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd0));
    run_layer(1, 1, 1, 1, 1, 1 + 1 + FLUSH_CYC, 1'b1);

    // 2x2 image, 3x3 kernel: first pixel hand-computed, rest from the formulas.
    fm_t  = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd2, 16'd3};
    pad_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++)
      exp_q.push_back(mk(fm_t[i], pad_t[i], 16'(i), i == 0, i == 8, 16'd0));
    gen_expected(2, 2, 1, 1, 3, 9);
    run_layer(2, 2, 1, 1, 3, 1 + 36 + FLUSH_CYC, 1'b1);

    // Same layer under backpressure.
    ready_mode = 1;
    gen_expected(2, 2, 1, 1, 3, 0);
    run_layer(2, 2, 1, 1, 3, 0, 1'b0);
    ready_mode = 0;

    bad_start(2, 2, 1, 1, 2);
    bad_start(2, 2, 0, 1, 3);
    bad_start(2, 2, 1, 1, 0);

    // Multi-kernel, multi-channel layer; last beat checked by hand.
    gen_expected(3, 4, 2, 2, 3, 0);
    run_layer(3, 4, 2, 2, 3, 1 + 432 + FLUSH_CYC, 1'b1);
    check("last_out_addr", last_seen.out, 16'd23);
    check("last_wt_addr", last_seen.wt, 16'd35);
    check("last_flags", {last_seen.pad, last_seen.first, last_seen.last}, 3'b101);

    // Asynchronous reset mid-layer, then a fresh layer from zero.
    gen_expected(3, 4, 2, 2, 3, 0);
    @(negedge clk);
    drive_cfg(3, 4, 2, 2, 3);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bus.mac_valid, bus.pad, bus.acc_first,
          bus.acc_last, bus.busy, bus.done, bus.cfg_err, bus.fm_addr,
          bus.wt_addr, bus.out_addr}, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    gen_expected(2, 2, 1, 1, 3, 0);
    run_layer(2, 2, 1, 1, 3, 1 + 36 + FLUSH_CYC, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/conv_loop_sched.md
Name: conv_loop_sched

Overview:
- Loop-nest scheduler that sequences one convolution layer on the CoreT MAC datapath.
- Walks output channels, output pixels, input channels and the kernel window in a fixed order.
- Per beat it issues feature-map address, weight address, zero-pad flag and accumulator framing (first/last) to the datapath; backpressure comes from the datapath.
- Sits between the layer-config registers and CoreT; one start/done transaction per layer.

Parameters:
- FM_AW, 16, feature-map address width
- WT_AW, 16, weight address width
- OUT_AW, 16, output-buffer address width
- FLUSH_CYC, 4, cycles waited after the last beat for the MAC pipeline to drain (must be 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin layer; sampled only in IDLE
- H  in  6  output/input height, 1..63
- W  in  6  output/input width, 1..63
- C  in  7  input channels, 1..127
- K  in  7  output channels (kernels), 1..127
- hk  in  3  kernel size, odd: 1, 3, 5, 7
- mac_ready  in  1  datapath accepts current beat
- mac_valid  out  1  beat valid
- fm_addr  out  FM_AW  (c*H + iy)*W + ix; 0 when pad=1
- pad  out  1  window tap falls outside the image; datapath substitutes 0
- wt_addr  out  WT_AW  ((k*C + c)*hk + ky)*hk + kx
- acc_first  out  1  first beat of an output pixel (clear accumulator)
- acc_last  out  1  last beat of an output pixel (write result)
- out_addr  out  OUT_AW  (k*H + y)*W + x
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse at layer completion
- cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0; effective immediately, mid-layer included. No resume after reset.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE, start=1, config legal: latch H, W, C, K, hk into shadow registers, go to RUN, busy=1 next cycle.
- IDLE, start=1, config illegal (any of H, W, C, K = 0; hk even or 0): cfg_err=1 for one cycle, stay in IDLE, busy stays 0.
- Inputs are ignored outside IDLE: start while busy, and config changes during a layer.
- Loop order, outermost first: k, y, x, c, ky, kx. All counters start at 0.
- Padding: p = (hk-1)/2, iy = y + ky - p, ix = x + kx - p (signed). pad = iy<0 | iy>=H | ix<0 | ix>=W.
- RUN: mac_valid=1 from the first RUN cycle; all beat outputs are registered.
- A beat advances only on mac_valid & mac_ready.
- While mac_ready=0, every beat output holds stable (no change, no glitch).
- acc_first=1 when c=0, ky=0, kx=0.
- acc_last=1 when c=C-1, ky=hk-1, kx=hk-1.
- out_addr is constant across all beats of one output pixel.
- Address generation: incremental adders preferred; multiplies are allowed if the outputs are still registered. Result must match the formulas exactly, truncated to the stated widths.
- After the final beat (all counters at max) is accepted: mac_valid=0 next cycle, state FLUSH.
- FLUSH counts FLUSH_CYC cycles, then DONE.
- DONE lasts one cycle: done=1 and busy=1. Next cycle: IDLE, busy=0.
- A start asserted in that DONE cycle is ignored.
- Total accepted beats = K*H*W*C*hk*hk.
- With mac_ready held at 1, latency from the start cycle to the done pulse = 1 + beats + FLUSH_CYC cycles.

Test Plan:
- H=W=C=K=1, hk=1, mac_ready=1, start at cycle 0:
  - one beat at cycle 1: fm_addr=0, wt_addr=0, out_addr=0, pad=0, acc_first=acc_last=1.
  - done at cycle 6 (FLUSH_CYC=4); busy=0 at cycle 7.
- H=W=2, C=K=1, hk=3, first output pixel:
  - 9 beats with pad pattern 1,1,1,1,0,0,1,0,0.
  - non-pad fm_addr sequence 0,1,2,3.
  - wt_addr 0..8; acc_first on beat 0, acc_last on beat 8.
  - 36 beats total, out_addr 0..3.
- Same config with mac_ready toggling 1,0,0,1 repeatedly:
  - outputs hold during the 0 cycles.
  - beat sequence identical to the previous test; total beats 36.
- start with hk=2, then with C=0:
  - cfg_err pulses once per start; busy, mac_valid and done stay 0.
- H=16, W=32, C=64, K=32, hk=3, mac_ready=1:
  - 9,437,184 beats.
  - last beat: out_addr=16383, wt_addr=18431, acc_last=1.
  - done exactly FLUSH_CYC+1 cycles after the last beat.
- rst_n low mid-RUN:
  - all outputs 0 asynchronously.
  - after release and a new start, the sequence restarts from k=y=x=c=0.
